// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: WIDTH-bit words in over valid/ready, MSB-first serial out.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             last_bit;
    logic             final_cycle;
    logic             xfer;

`ifdef SER_PARITY_EN
    logic par;

    function automatic logic even_par(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    assign final_cycle = (state == PARITY);
`else
    assign final_cycle = last_bit;
`endif

    assign last_bit  = (state == SHIFT) && (cnt == LAST_CNT);
    assign din_ready = !rst && ((state == IDLE) || final_cycle);
    assign xfer      = din_valid && din_ready;
    assign busy      = (state != IDLE);

    // Load takes priority: xfer can only occur in IDLE or on a word's final cycle,
    // so the MSB of the next word is registered straight onto sout with no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
`ifdef SER_PARITY_EN
            par        <= 1'b0;
`endif
        end else if (xfer) begin
            state      <= SHIFT;
            cnt        <= '0;
            shreg      <= {din[WIDTH-2:0], 1'b0};
            sout       <= din[WIDTH-1];
            sout_valid <= 1'b1;
`ifdef SER_PARITY_EN
            par        <= even_par(din);
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (!last_bit) begin
                        sout  <= shreg[WIDTH-1];
                        shreg <= shreg << 1;
                        cnt   <= cnt + CW'(1);
                    end else begin
`ifdef SER_PARITY_EN
                        state <= PARITY;
                        sout  <= par;
`else
                        state      <= IDLE;
                        cnt        <= '0;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
`endif
                    end
                end
                default: begin
                    // IDLE, or PARITY without a follow-on word: park the line at zero
                    state      <= IDLE;
                    cnt        <= '0;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: stimulus pushes expected (bit, cycle) pairs,
// a negedge monitor pops and compares them. Define SER_PARITY_EN to cover the parity build.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int WAITS = WIDTH;
`else
    localparam int WAITS = WIDTH - 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;

    typedef struct {
        logic b;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sout      (sout),
        .sout_valid(sout_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every serial bit must match the scoreboard both in value and in cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sout_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("sout_bit", int'(sout), int'(e.b));
                check("sout_cycle", cyc, e.cyc);
            end
        end else begin
            check("idle_sout_zero", int'(sout), 0);
        end
        check("busy_eq_valid", int'(busy), int'(sout_valid));
    end

    // Present w with din_valid; scramble din while held off; expect exp_waits not-ready cycles.
    task automatic send(input logic [WIDTH-1:0] w, input int exp_waits);
        int waits = 0;
        din_valid = 1'b1;
        din = w;
        #1;
        while (!din_ready && waits < 40) begin
            din = WIDTH'($urandom);
            @(negedge clk);
            #1;
            waits++;
        end
        if (!din_ready) begin
            check("ready_timeout", waits, exp_waits);
            din_valid = 1'b0;
            return;
        end
        check("ready_wait", waits, exp_waits);
        din = w;
        for (int k = 0; k < WIDTH; k++)
            q.push_back('{b: w[WIDTH-1-k], cyc: cyc + 1 + k});
`ifdef SER_PARITY_EN
        q.push_back('{b: ^w, cyc: cyc + 1 + WIDTH});
`endif
        @(posedge clk);
        #1;
        din = WIDTH'($urandom);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        // Reset asserted from time zero with no clock edge yet
        #3;
        check("rst_sout", int'(sout), 0);
        check("rst_sout_valid", int'(sout_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_din_ready", int'(din_ready), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("post_rst_din_ready", int'(din_ready), 1);

        // Single word 8'hD0, then return to idle
        send(8'hD0, 0);
        din_valid = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);
        #1 check("idle_ready", int'(din_ready), 1);

        // Held valid: D0 then B5 back to back; also scrambled din while held off
        send(8'hD0, 0);
        send(8'hB5, WAITS);
        send(8'h3C, WAITS);
        send(8'h96, WAITS);
        din_valid = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

        // Reset during bit 4 of 8'hFF, then a clean 8'h0F
        send(8'hFF, 0);
        din_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        #1 rst = 1'b1;
        #1;
        check("midrst_sout", int'(sout), 0);
        check("midrst_sout_valid", int'(sout_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_din_ready", int'(din_ready), 0);
        q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check("midrst_release_ready", int'(din_ready), 1);
        send(8'h0F, 0);
        din_valid = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

`ifdef SER_PARITY_EN
        // Parity 1 for D0, parity 0 for C0, back to back
        send(8'hD0, 0);
        send(8'hC0, WAITS);
        din_valid = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);
`endif

        // Boundary words
        send(8'h01, 0);
        send(8'h80, WAITS);
        din_valid = 1'b0;

        n = 0;
        while ((busy || q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("drain_busy", int'(busy), 0);
        check("scoreboard_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
